// File: rtl/sprite_rect_pkg.sv
// Shared types and default colours for the sprite_rect block.
package sprite_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } state_t;

    // Resolved direction set; up/left already win over down/right.
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    localparam int DEFAULT_RGB_W = 3;
    localparam logic [DEFAULT_RGB_W-1:0] COLOR_WHITE = '1;
    localparam logic [DEFAULT_RGB_W-1:0] COLOR_BLACK = '0;

endpackage

// File: rtl/sprite_rect_if.sv
// Pixel, tick and direction bus between a video timing source and sprite_rect.
interface sprite_rect_if #(
    parameter int COORD_W = 10,
    parameter int RGB_W   = 3
);
    logic               tick;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               pix_valid;
    logic               up_n;
    logic               down_n;
    logic               left_n;
    logic               right_n;
    logic [RGB_W-1:0]   rgb;
    logic               hit;
    logic [COORD_W-1:0] posx;
    logic [COORD_W-1:0] posy;

    modport master (
        output tick, row, col, pix_valid, up_n, down_n, left_n, right_n,
        input  rgb, hit, posx, posy
    );

    modport slave (
        input  tick, row, col, pix_valid, up_n, down_n, left_n, right_n,
        output rgb, hit, posx, posy
    );
endinterface

// File: rtl/sprite_rect_tick_divider.sv
// Divides game-update strobes down to one move event every PRESCALE strobes.
module tick_divider #(
    parameter int PRESCALE = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    output logic o_event
);
    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    logic [7:0] r_cnt;

    assign o_event = i_tick && !reset && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= o_event ? 8'd0 : r_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/sprite_rect.sv
// Movable filled rectangle sprite with clamped motion and 1-cycle pixel draw.
// Optional step ramping is enabled by defining SPRITE_RECT_ACCEL_EN.
//
//   state     | meaning
//   ST_IDLE   | no direction active at the last move event; step is 1
//   ST_MOVING | a direction was active at the last move event
module sprite_rect
    import sprite_pkg::*;
#(
    parameter int               COORD_W  = 10,
    parameter int               RGB_W    = DEFAULT_RGB_W,
    parameter logic [RGB_W-1:0] COLOR    = {RGB_W{1'b1}},
    parameter int               WIDTH    = 10,
    parameter int               HEIGHT   = 100,
    parameter int               START_X  = 100,
    parameter int               START_Y  = 100,
    parameter int               LIMIT_X  = 640,
    parameter int               LIMIT_Y  = 480,
    parameter int               PRESCALE = 10,
    parameter int               MAX_STEP = 4
) (
    input  logic         clk,
    input  logic         reset,
    sprite_rect_if.slave bus
);
    typedef logic [COORD_W:0] ext_t;

    localparam ext_t WIDTH_E  = ext_t'(WIDTH);
    localparam ext_t HEIGHT_E = ext_t'(HEIGHT);
    localparam ext_t LIMIT_XE = ext_t'(LIMIT_X);
    localparam ext_t LIMIT_YE = ext_t'(LIMIT_Y);
    localparam ext_t MAX_XE   = ext_t'(LIMIT_X - WIDTH);
    localparam ext_t MAX_YE   = ext_t'(LIMIT_Y - HEIGHT);
    localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);

    if (MAX_STEP < 1 || MAX_STEP > 15) begin : g_bad_max_step
        $error("sprite_rect: MAX_STEP must be 1..15");
    end
    if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
        $error("sprite_rect: PRESCALE must be 1..255");
    end

    logic               w_event;
    dir_t               w_dir;
    logic               w_any;
    logic [3:0]         w_step;
    ext_t               w_step_e;
    ext_t               w_px;
    ext_t               w_py;
    ext_t               w_nx;
    ext_t               w_ny;
    ext_t               w_col;
    ext_t               w_row;
    logic               w_hit;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [COORD_W-1:0] r_posx;
    logic [COORD_W-1:0] r_posy;
    logic               r_hit;
    logic [RGB_W-1:0]   r_rgb;

    tick_divider #(.PRESCALE(PRESCALE)) u_div (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (bus.tick),
        .o_event (w_event)
    );

    always_comb begin
        w_dir       = '0;
        w_dir.up    = ~bus.up_n;
        w_dir.down  = bus.up_n & ~bus.down_n;
        w_dir.left  = ~bus.left_n;
        w_dir.right = bus.left_n & ~bus.right_n;
    end

    assign w_any = |w_dir;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_event && w_any)  w_state_nxt = ST_MOVING;
            ST_MOVING: if (w_event && !w_any) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef SPRITE_RECT_ACCEL_EN
    localparam logic [3:0] STEP_MAX = 4'(MAX_STEP);

    logic [3:0] r_step;
    dir_t       r_dir;

    // Step used by this event; a changed direction set restarts the ramp at 1.
    always_comb begin
        w_step = 4'd1;
        if (r_state == ST_MOVING && w_dir == r_dir) begin
            w_step = (r_step < STEP_MAX) ? r_step + 4'd1 : r_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step <= 4'd1;
            r_dir  <= '0;
        end else if (w_event) begin
            r_step <= w_step;
            r_dir  <= w_dir;
        end
    end
`else
    assign w_step = 4'd1;
`endif

    assign w_step_e = ext_t'(w_step);
    assign w_px     = {1'b0, r_posx};
    assign w_py     = {1'b0, r_posy};

    always_comb begin
        w_nx = w_px;
        w_ny = w_py;
        if (w_dir.up) begin
            w_ny = (w_py < w_step_e) ? '0 : w_py - w_step_e;
        end else if (w_dir.down) begin
            w_ny = (w_py + HEIGHT_E + w_step_e > LIMIT_YE) ? MAX_YE : w_py + w_step_e;
        end
        if (w_dir.left) begin
            w_nx = (w_px < w_step_e) ? '0 : w_px - w_step_e;
        end else if (w_dir.right) begin
            w_nx = (w_px + WIDTH_E + w_step_e > LIMIT_XE) ? MAX_XE : w_px + w_step_e;
        end
    end

    // Compared against the current position, so an updating cycle draws the old one.
    assign w_col = {1'b0, bus.col};
    assign w_row = {1'b0, bus.row};
    assign w_hit = bus.pix_valid
                 && (w_col >= w_px) && (w_col < w_px + WIDTH_E)
                 && (w_row >= w_py) && (w_row < w_py + HEIGHT_E);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_posx <= START_XC;
            r_posy <= START_YC;
            r_hit  <= 1'b0;
            r_rgb  <= '0;
        end else begin
            if (w_event) begin
                r_posx <= w_nx[COORD_W-1:0];
                r_posy <= w_ny[COORD_W-1:0];
            end
            r_hit <= w_hit;
            r_rgb <= w_hit ? COLOR : '0;
        end
    end

    assign bus.rgb  = r_rgb;
    assign bus.hit  = r_hit;
    assign bus.posx = r_posx;
    assign bus.posy = r_posy;
endmodule

// File: doc/sprite_rect.md
SPRITE_RECT -- requirements
Module: sprite_rect

Interface
REQ-001 Parameter COORD_W, 10, width of row/col/position buses.
REQ-002 Parameter RGB_W, 3, colour bus width.
REQ-003 Parameter COLOR, all-ones of RGB_W, fill colour.
REQ-004 Parameter WIDTH, 10, and HEIGHT, 100, rectangle size in pixels.
REQ-005 Parameter START_X, 100, and START_Y, 100, position after reset.
REQ-006 Parameter LIMIT_X, 640, and LIMIT_Y, 480, exclusive playfield bounds.
REQ-007 Parameter PRESCALE, 10, ticks per move event (1..255).
REQ-008 Parameter MAX_STEP, 4, maximum pixels per move event (1..15).
REQ-009 clk  in  1  pixel clock; all logic on rising edge.
REQ-010 reset  in  1  reset, synchronous, active-high.
REQ-011 tick  in  1  one-cycle game-update strobe.
REQ-012 row, col  in  COORD_W each  current pixel coordinates.
REQ-013 pix_valid  in  1  row/col is inside the visible area.
REQ-014 up_n, down_n, left_n, right_n  in  1 each  active-low direction commands, synchronous to clk.
REQ-015 rgb  out  RGB_W  registered pixel colour.
REQ-016 hit  out  1  registered: pixel lies inside the rectangle.
REQ-017 posx, posy  out  COORD_W each  current top-left position.

Function
REQ-018 The prescaler SHALL count tick strobes 0..PRESCALE-1 and raise one move event on the strobe that wraps it to 0.
REQ-019 Vertical direction: up_n low SHALL select up; otherwise down_n low SHALL select down; both low SHALL select up.
REQ-020 Horizontal direction: left_n low SHALL select left; otherwise right_n low SHALL select right; both low SHALL select left.
REQ-021 Each axis SHALL move independently by the current step on every move event.
REQ-022 Moving up/left SHALL clamp the position at 0 when it is below step.
REQ-023 Moving down/right SHALL clamp the position at LIMIT_Y-HEIGHT or LIMIT_X-WIDTH when pos+size+step exceeds the limit.
REQ-024 Limit arithmetic SHALL use COORD_W+1 bits so that no wrap-around occurs.
REQ-025 FSM states SHALL be IDLE (no direction active) and MOVING (at least one direction active), evaluated on move events only.
REQ-026 IDLE SHALL set step to 1; IDLE->MOVING when any direction is active at a move event.
REQ-027 MOVING with an unchanged direction set SHALL increment step by 1 per move event, saturating at MAX_STEP.
REQ-028 MOVING with a changed direction set SHALL reset step to 1 and apply the move at step 1.
REQ-029 MOVING->IDLE when no direction is active at a move event.
REQ-030 Drawing latency SHALL be 1 cycle: rgb/hit at cycle n+1 reflect row/col/pix_valid at cycle n.
REQ-031 Drawing SHALL use the pre-update position in a cycle in which the position changes.
REQ-032 hit SHALL be 1 when pix_valid and posx<=col<posx+WIDTH and posy<=row<posy+HEIGHT.
REQ-033 rgb SHALL be COLOR when hit is 1 and zero otherwise.

Reset
REQ-034 While reset is high: posx=START_X, posy=START_Y, prescaler=0, step=1, FSM=IDLE, rgb=0, hit=0.
REQ-035 Reset SHALL dominate tick and direction inputs in the same cycle; a mid-ramp step SHALL be discarded.

Configuration
REQ-036 Macro SPRITE_RECT_ACCEL_EN defined: step ramping per REQ-026..REQ-028.
REQ-037 Macro absent: step SHALL be fixed at 1, the step register SHALL not exist, and MAX_STEP SHALL be ignored.

Structure
REQ-038 Package sprite_pkg SHALL hold the FSM state typedef, the direction-set typedef, and the default colour constants.
REQ-039 The prescaler SHALL be sub-module tick_divider (parameter PRESCALE; ports: clk, reset, tick, event).

Verification
REQ-040 PRESCALE=10, up_n low, 30 ticks -> posy 100->97, one step per 10 ticks (accel off).
REQ-041 ACCEL_EN, MAX_STEP=4, PRESCALE=1, down_n held 6 events -> posy deltas 1,2,3,4,4,4, ending at 118.
REQ-042 posy=2, up held, step 4 -> posy=0 and held at 0; posy=378, down held -> posy clamps at 380.
REQ-043 up_n and down_n both low -> up; left_n and right_n both low -> left; direction change mid-ramp -> step back to 1.
REQ-044 Pixel scan with pix_valid=1, row=100, col=109 -> next cycle hit=1 and rgb=COLOR; col=110 -> hit=0; pix_valid=0 -> rgb=0.
REQ-045 Reset asserted mid-ramp at posy=150 -> next cycle posy=100, step=1, FSM=IDLE, rgb=0.
